// File: rtl/reg_fifo_pkg.sv
// Shared defaults and sizing helper for the register-based synchronous FIFO.
package reg_fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32'd8;
  localparam int unsigned DEFAULT_DEPTH = 32'd4;

  // Pointer width for a given number of entries (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    int unsigned w;
    w = 32'd1;
    while ((32'd1 << w) < depth) begin
      w = w + 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/reg_fifo_mem.sv
// DEPTH x WIDTH register storage: one decoded write port, combinational read mux.
module reg_fifo_mem
  import reg_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] w_wr_sel;

  // Decode the write address into one enable per entry.
  always_comb begin
    w_wr_sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i_wr_en && (i_wr_addr == AW'(i))) begin
        w_wr_sel[i] = 1'b1;
      end else begin
        w_wr_sel[i] = 1'b0;
      end
    end
  end

  // Entry registers; contents are not reset, the pointers make stale data unreachable.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_wr_sel[i]) begin
        r_mem[i] <= i_wr_data;
      end
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/reg_fifo_sync.sv
// Single-clock FIFO with registered read data, occupancy count, level flags
// and one-cycle overflow/underflow pulses.
module reg_fifo_sync
  import reg_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 32'd1,
  parameter int unsigned AE_LEVEL = 32'd1,
  localparam int unsigned PW = ptr_width(DEPTH),
  localparam int unsigned CW = PW + 32'd1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic          AF_RST  = (AF_LEVEL == 32'd0);

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_full;
  logic             r_empty;
  logic             r_af;
  logic             r_ae;
  logic             r_ovf;
  logic             r_udf;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_mem_rd;

  reg_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_mem_rd)
  );

  // Judge both requests against the current flags and compute the next occupancy.
  always_comb begin
    w_wr_acc    = wr_en & ~r_full;
    w_rd_acc    = rd_en & ~r_empty;
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CW'(32'd1);
      2'b01:   w_count_nxt = r_count - CW'(32'd1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, count, read word, flags (from next count so they track count) and pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_af      <= AF_RST;
      r_ae      <= 1'b1;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PW'(32'd1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_rd_acc) begin
        r_rd_ptr  <= r_rd_ptr + PW'(32'd1);
        r_rd_data <= w_mem_rd;
      end else begin
        r_rd_ptr  <= r_rd_ptr;
        r_rd_data <= r_rd_data;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_C);
      r_empty <= (w_count_nxt == CW'(32'd0));
      r_af    <= (w_count_nxt >= AF_C);
      r_ae    <= (w_count_nxt <= AE_C);
      r_ovf   <= wr_en & r_full;
      r_udf   <= rd_en & r_empty;
    end
  end

  assign rd_data      = r_rd_data;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_reg_fifo_sync.sv
// Scoreboard bench for reg_fifo_sync: a queue-based reference model produces
// per-cycle expectations, a monitor compares them one edge later.
module tb_reg_fifo_sync;

  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  reg_fifo_sync #(
    .WIDTH    (8),
    .DEPTH    (4),
    .AF_LEVEL (3),
    .AE_LEVEL (1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rd;
    int         cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mq[$];
  logic [7:0] m_rd;
  int         total;
  int         bad;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // One cycle of stimulus; the model applies the FIFO rules to a plain queue.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    exp_t e;
    int   n;
    @(negedge clk);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    n     = mq.size();
    e.ovf = w && (n == DEPTH);
    e.udf = r && (n == 0);
    if (r && n > 0) m_rd = mq.pop_front();
    if (w && n < DEPTH) mq.push_back(d);
    n       = mq.size();
    e.rd    = m_rd;
    e.cnt   = n;
    e.full  = (n == DEPTH);
    e.empty = (n == 0);
    e.af    = (n >= AF);
    e.ae    = (n <= AE);
    exp_q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_empty"}, 64'(empty), 64'd1);
    chk({tag, "_ae"}, 64'(almost_empty), 64'd1);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_af"}, 64'(almost_full), 64'd0);
    chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_udf"}, 64'(underflow), 64'd0);
  endtask

  // Monitor: one expectation per clocked cycle, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_data", 64'(rd_data), 64'(e.rd));
        chk("count", 64'(count), 64'(e.cnt));
        chk("full", 64'(full), 64'(e.full));
        chk("empty", 64'(empty), 64'(e.empty));
        chk("almost_full", 64'(almost_full), 64'(e.af));
        chk("almost_empty", 64'(almost_empty), 64'(e.ae));
        chk("overflow", 64'(overflow), 64'(e.ovf));
        chk("underflow", 64'(underflow), 64'(e.udf));
      end
    end
  end

  initial begin
    total   = 0;
    bad     = 0;
    m_rd    = 8'h00;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Fill, overflow, drain in order
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Read while empty
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Interleaved traffic across the pointer wrap
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'(8'h60 + i), 1'b0);
      step(1'b0, 8'h00, 1'b1);
    end

    // Full with both requests, then empty with both requests
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h70 + i), 1'b0);
    step(1'b1, 8'h77, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h88, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Randomized traffic alternating write-heavy and read-heavy phases
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < 60; c++) begin
        step($urandom_range(0, 99) < ((p % 2 == 0) ? 75 : 25),
             8'($urandom),
             $urandom_range(0, 99) < ((p % 2 == 0) ? 25 : 75));
      end
    end

    // Asynchronous reset with three entries stored
    while (mq.size() > 0) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset("mid");
    mq.delete();
    m_rd = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
